// File: rtl/poly_tone_engine_pkg.sv
// Shared constants, prefix FSM states and note tables for the polyphonic tone engine.
package piano_pkg;

    localparam logic [7:0]  SCAN_F0   = 8'hF0;
    localparam logic [7:0]  SCAN_E0   = 8'hE0;
    localparam int unsigned NUM_NOTES = 8;
    localparam logic [3:0]  NOTE_NONE = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } prefix_state_t;

    // Home-row scan codes mapped to the C4..C5 scale; anything else is silent.
    function automatic logic [3:0] scan_to_note(input logic [7:0] code);
        logic [3:0] note;
        case (code)
            8'h1C:   note = 4'd0;
            8'h1B:   note = 4'd1;
            8'h23:   note = 4'd2;
            8'h2B:   note = 4'd3;
            8'h34:   note = 4'd4;
            8'h33:   note = 4'd5;
            8'h3B:   note = 4'd6;
            8'h42:   note = 4'd7;
            default: note = NOTE_NONE;
        endcase
        return note;
    endfunction

    // Note frequencies in centi-Hz.
    function automatic int unsigned note_freq_chz(input logic [3:0] note);
        int unsigned f;
        case (note)
            4'd0:    f = 26163;
            4'd1:    f = 29366;
            4'd2:    f = 32963;
            4'd3:    f = 34923;
            4'd4:    f = 39200;
            4'd5:    f = 44000;
            4'd6:    f = 49388;
            4'd7:    f = 52325;
            default: f = 26163;
        endcase
        return f;
    endfunction

    // Rounded half-period in clock cycles: clk_hz*100/(2*f_chz).
    function automatic int unsigned half_period(input logic [3:0] note, input int unsigned clk_hz);
        logic [63:0] f;
        logic [63:0] num;
        f   = 64'(note_freq_chz(note));
        num = 64'(clk_hz) * 64'd50 + (f >> 1);
        return 32'(num / f);
    endfunction

endpackage

// File: rtl/poly_tone_engine_if.sv
// Scan-code byte stream from the PS/2 receiver: one-cycle valid strobe plus byte.
interface poly_tone_engine_if;

    logic       iValid;
    logic [7:0] iData;

    modport master (output iValid, output iData);
    modport slave  (input  iValid, input  iData);

endinterface

// File: rtl/poly_tone_engine_voice.sv
// Single square-wave voice: loadable half-period counter with a toggling level.
module tone_voice
    import piano_pkg::*;
#(
    parameter int unsigned DIV_W = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [3:0]       i_note,
    input  logic [DIV_W-1:0] i_half,
    output logic             o_active,
    output logic             o_level,
    output logic [3:0]       o_note
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_half;
    logic             r_active;
    logic             r_level;
    logic [3:0]       r_note;
    logic             w_wrap;

    assign w_wrap = (r_cnt == r_half - DIV_W'(1));

    // Load wins over clear and over a wrap on the same edge; clear forces the level low at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_half   <= '0;
            r_active <= 1'b0;
            r_level  <= 1'b0;
            r_note   <= NOTE_NONE;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_half   <= i_half;
            r_active <= 1'b1;
            r_level  <= 1'b0;
            r_note   <= i_note;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_level  <= 1'b0;
        end else if (r_active) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    assign o_active = r_active;
    assign o_level  = r_level;
    assign o_note   = r_note;

endmodule

// File: rtl/poly_tone_engine.sv
// Polyphonic buzzer engine: PS/2 make/break decode, voice allocation and PWM mixing.
module poly_tone_engine
    import piano_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CLK_HZ     = 1000000,
    parameter int unsigned DIV_W      = 13
) (
    input  logic                  iClk,
    input  logic                  iReset,
    poly_tone_engine_if.slave     scan,
    input  logic                  iMute,
    output logic                  oPWM,
    output logic [NUM_VOICES-1:0] oActive,
    output logic [3:0]            oLastNote
);

    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CW = $clog2(NUM_VOICES + 1);

    prefix_state_t r_state;
    prefix_state_t w_state_nxt;
    logic          w_make;
    logic          w_break;

    logic [3:0]            w_note;
    logic                  w_known;
    logic [DIV_W-1:0]      w_half;
    logic [DIV_W-1:0]      w_half_tab [NUM_NOTES];
    logic [NUM_VOICES-1:0] w_active;
    logic [NUM_VOICES-1:0] w_level;
    logic [3:0]            w_vnote [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_match;
    logic                  w_hit;
    logic                  w_free_found;
    logic [IW-1:0]         w_free_idx;
    logic                  w_do_make;
    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_clear;

    logic [IW-1:0] r_steal;
    logic [3:0]    r_last;
    logic [CW-1:0] r_car;
    logic [CW-1:0] w_sum;
    logic          r_pwm;

    // Half-period table built from constant calls so no divider is synthesised.
    for (genvar gn = 0; gn < NUM_NOTES; gn++) begin : g_half
        assign w_half_tab[gn] = DIV_W'(half_period(4'(gn), CLK_HZ));
    end

    assign w_note  = scan_to_note(scan.iData);
    assign w_known = (w_note != NOTE_NONE);
    assign w_half  = w_half_tab[w_note[2:0]];

    // Prefix FSM state register.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Prefix FSM next state and make/break event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_break     = 1'b0;
        if (scan.iValid) begin
            case (r_state)
                ST_IDLE: begin
                    if (scan.iData == SCAN_F0)      w_state_nxt = ST_BRK;
                    else if (scan.iData == SCAN_E0) w_state_nxt = ST_EXT;
                    else                            w_make      = 1'b1;
                end
                ST_BRK: begin
                    w_break     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    w_state_nxt = (scan.iData == SCAN_F0) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Voice allocation: repeat detection, lowest idle voice, else round-robin steal.
    always_comb begin
        w_match      = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_load       = '0;
        w_clear      = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            w_match[v] = w_active[v] && (w_vnote[v] == w_note);
            if (!w_active[v] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(v);
            end
        end
        w_hit     = |w_match;
        w_do_make = w_make && w_known && !w_hit;
        if (w_do_make) begin
            if (w_free_found) w_load[w_free_idx] = 1'b1;
            else              w_load[r_steal]    = 1'b1;
        end
        if (w_break && w_known) w_clear = w_match;
    end

    // Steal pointer and last-note register.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_steal <= '0;
            r_last  <= NOTE_NONE;
        end else begin
            if (w_do_make && !w_free_found) begin
                r_steal <= (r_steal == IW'(NUM_VOICES - 1)) ? '0 : r_steal + IW'(1);
            end
            if (w_make && w_known) r_last <= w_note;
        end
    end

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
        tone_voice #(.DIV_W(DIV_W)) u_voice (
            .i_clk    (iClk),
            .i_rst    (iReset),
            .i_load   (w_load[gv]),
            .i_clear  (w_clear[gv]),
            .i_note   (w_note),
            .i_half   (w_half),
            .o_active (w_active[gv]),
            .o_level  (w_level[gv]),
            .o_note   (w_vnote[gv])
        );
    end

    // Count of voices currently driving high.
    always_comb begin
        w_sum = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            w_sum = w_sum + CW'(w_active[v] & w_level[v]);
        end
    end

    // Time-division carrier and registered PWM output.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_car <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_car <= (r_car == CW'(NUM_VOICES - 1)) ? '0 : r_car + CW'(1);
            r_pwm <= (r_car < w_sum) && !iMute;
        end
    end

    assign oPWM      = r_pwm;
    assign oActive   = w_active;
    assign oLastNote = r_last;

endmodule

// File: tb/tb_poly_tone_engine.sv
// Self-checking bench for poly_tone_engine: vector table with scoreboard plus timed sequences.
module tb_poly_tone_engine;
    import piano_pkg::*;

    localparam int unsigned NV = 4;

    typedef struct {
        bit         rst;
        logic [7:0] data;
        logic [3:0] act;
        logic [3:0] last;
    } vec_t;

    typedef struct {
        logic [3:0] act;
        logic [3:0] last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mute = 1'b0;
    logic          pwm;
    logic [NV-1:0] act;
    logic [3:0]    last;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    vec_t tbl[$];
    exp_t sb[$];
    exp_t e;

    poly_tone_engine_if ifc();

    poly_tone_engine #(
        .NUM_VOICES (NV),
        .CLK_HZ     (1000000),
        .DIV_W      (13)
    ) dut (
        .iClk      (clk),
        .iReset    (rst),
        .scan      (ifc.slave),
        .iMute     (mute),
        .oPWM      (pwm),
        .oActive   (act),
        .oLastNote (last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        n_vec++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        ifc.iValid = 1'b1;
        ifc.iData  = b;
        tick();
        ifc.iValid = 1'b0;
        ifc.iData  = 8'h00;
    endtask

    // Runs n cycles recording PWM highs relative to base; optionally re-sends 0x1C at step rep_at.
    task automatic watch(input int n, input int rep_at, input int base,
                         output int first, output int lastk, output int highs);
        first = -1;
        lastk = -1;
        highs = 0;
        for (int j = 0; j < n; j++) begin
            if (j == rep_at) begin
                ifc.iValid = 1'b1;
                ifc.iData  = 8'h1C;
            end
            tick();
            ifc.iValid = 1'b0;
            if (pwm) begin
                if (first < 0) first = cyc - base;
                lastk = cyc - base;
                highs++;
            end
        end
    endtask

    task automatic wait_pwm_high(input string name, input int bound);
        int seen;
        seen = 0;
        for (int j = 0; j < bound && seen == 0; j++) begin
            tick();
            if (pwm) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int base, first, lastk, highs;
        ifc.iValid = 1'b0;
        ifc.iData  = 8'h00;

        // Make, repeat, break, stray break.
        tbl.push_back('{1'b1, 8'h1C, 4'b0001, 4'd0});
        tbl.push_back('{1'b0, 8'h1C, 4'b0001, 4'd0});
        tbl.push_back('{1'b0, 8'hF0, 4'b0001, 4'd0});
        tbl.push_back('{1'b0, 8'h1C, 4'b0000, 4'd0});
        tbl.push_back('{1'b0, 8'hF0, 4'b0000, 4'd0});
        tbl.push_back('{1'b0, 8'h1C, 4'b0000, 4'd0});
        // Extended prefixes and unmapped codes never allocate.
        tbl.push_back('{1'b1, 8'hE0, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'h1C, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'hE0, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'hF0, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'h1C, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'h15, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'hF0, 4'b0000, 4'd15});
        tbl.push_back('{1'b0, 8'h15, 4'b0000, 4'd15});
        // Fill all voices, steal voice0 then voice1, refill lowest idle.
        tbl.push_back('{1'b1, 8'h1C, 4'b0001, 4'd0});
        tbl.push_back('{1'b0, 8'h1B, 4'b0011, 4'd1});
        tbl.push_back('{1'b0, 8'h23, 4'b0111, 4'd2});
        tbl.push_back('{1'b0, 8'h2B, 4'b1111, 4'd3});
        tbl.push_back('{1'b0, 8'h34, 4'b1111, 4'd4});
        tbl.push_back('{1'b0, 8'h33, 4'b1111, 4'd5});
        tbl.push_back('{1'b0, 8'hF0, 4'b1111, 4'd5});
        tbl.push_back('{1'b0, 8'h34, 4'b1110, 4'd5});
        tbl.push_back('{1'b0, 8'h3B, 4'b1111, 4'd6});
        tbl.push_back('{1'b0, 8'hF0, 4'b1111, 4'd6});
        tbl.push_back('{1'b0, 8'h1B, 4'b1111, 4'd6});
        tbl.push_back('{1'b0, 8'hF0, 4'b1111, 4'd6});
        tbl.push_back('{1'b0, 8'h33, 4'b1101, 4'd6});

        // Reset state.
        do_reset();
        chk("reset_active", act, 0);
        chk("reset_pwm", pwm, 0);
        chk("reset_last", last, 4'd15);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            sb.push_back('{tbl[i].act, tbl[i].last});
            send(tbl[i].data);
            e = sb.pop_front();
            chk($sformatf("vec%0d_active", i), act, e.act);
            chk($sformatf("vec%0d_last", i), last, e.last);
        end
        chk("scoreboard_empty", sb.size(), 0);

        // Single C4 voice: level high from edge 1911 to 3822; a repeat at step 1000 must not restart it.
        do_reset();
        send(8'h1C);
        base = cyc;
        watch(4000, 999, base, first, lastk, highs);
        chk("c4_active", act, 4'b0001);
        chk_range("c4_first_high", first, 1912, 1915);
        chk_range("c4_last_high", lastk, 3819, 3822);
        chk_range("c4_quarter_duty", highs, 477, 478);

        // Break while sounding: silence from the following cycle on.
        wait_pwm_high("c4_high_again", 3000);
        send(8'hF0);
        send(8'h1C);
        chk("brk_active", act, 4'b0000);
        tick();
        watch(4000, -1, cyc, first, lastk, highs);
        chk("brk_silent", highs, 0);

        // Steal reloads voice0 with G4 half-period 1276.
        do_reset();
        send(8'h1C);
        send(8'h1B);
        send(8'h23);
        send(8'h2B);
        send(8'h34);
        base = cyc;
        chk("steal_last", last, 4'd4);
        send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h23);
        send(8'hF0); send(8'h2B);
        chk("steal_active", act, 4'b0001);
        watch(1400, -1, base, first, lastk, highs);
        chk_range("g4_first_high", first, 1277, 1280);

        // Mute with four voices held, then asynchronous reset mid-note.
        do_reset();
        send(8'h1C);
        send(8'h1B);
        send(8'h23);
        send(8'h2B);
        wait_pwm_high("poly_high", 4000);
        mute = 1'b1;
        tick();
        watch(3000, -1, cyc, first, lastk, highs);
        chk("mute_silent", highs, 0);
        chk("mute_active", act, 4'b1111);
        mute = 1'b0;
        wait_pwm_high("unmute_high", 4000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_active", act, 0);
        chk("async_pwm", pwm, 0);
        chk("async_last", last, 4'd15);
        tick();
        chk("held_pwm", pwm, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/poly_tone_engine.md
Name: poly_tone_engine

Overview:
- Polyphonic successor to the single-tone buzzer path.
- Consumes PS/2 scan-code bytes (valid strobe plus byte) from the PS/2 receiver.
- Tracks key make/break events and allocates up to NUM_VOICES simultaneous notes to square-wave voices.
- Time-division-mixes the voices onto one PWM pin for the buzzer.

Parameters:
- NUM_VOICES, 4, number of simultaneous voices (1..8).
- CLK_HZ, 1000000, iClk frequency; used for the half-period table.
- DIV_W, 13, width of the per-voice half-period counter. Must hold the largest table entry.

Ports:
- iClk  in  1  system clock (1 MHz domain).
- iReset  in  1  asynchronous, active-high reset.
- iValid  in  1  one-cycle strobe: iData holds a new scan-code byte.
- iData  in  8  PS/2 scan-code byte.
- iMute  in  1  forces oPWM low; voice state keeps running.
- oPWM  out  1  mixed buzzer output, registered.
- oActive  out  NUM_VOICES  per-voice busy mask.
- oLastNote  out  4  note index of the last accepted make. Value 15 means none.

Behaviour:
- Reset: all voices idle with counters and levels 0; oActive=0; oPWM=0; oLastNote=15; prefix FSM in IDLE; steal pointer 0.
- Prefix FSM, advanced only on iValid:
  - IDLE: on 0xF0 go to BRK; on 0xE0 go to EXT; on any other byte issue a make(byte) and stay in IDLE.
  - BRK: issue a break(byte), go to IDLE.
  - EXT: on 0xF0 go to EXT_BRK; on any other byte go to IDLE and discard it.
  - EXT_BRK: go to IDLE and discard the byte.
- Decode: a scan code not in the package table is ignored (no voice change).
- make(note), applied at the edge after iValid, so oActive updates 1 cycle after the strobe:
  - If an active voice already holds the note (typematic repeat), no change.
  - Otherwise use the lowest-index idle voice.
  - If none is idle, steal the voice at the steal pointer and advance the pointer modulo NUM_VOICES.
  - The chosen voice loads the note's half-period, clears counter and level, and sets active.
  - oLastNote is set to the note.
- break(note):
  - Every active voice holding the note is cleared to idle; its level is forced to 0 the same edge.
  - A break for a note not sounding has no effect.
- Voice:
  - While active, the counter increments each cycle.
  - At half-1 the counter wraps to 0 and the level toggles.
  - Square period is 2*half cycles.
- Mixer:
  - Carrier counter cycles 0..NUM_VOICES-1 every cycle.
  - S = number of active voices with level 1.
  - oPWM is registered as (carrier < S) and not iMute.
  - All voices high gives constant 1; no voices gives constant 0.
- Simultaneous events: only one byte per iValid, so make and break never coincide. A make landing on the edge a voice wraps takes precedence (reload).
- Reset mid-note: everything returns to reset values asynchronously; no residual pulse on oPWM.

Decomposition:
- Package piano_pkg holds:
  - SCAN_F0=0xF0, SCAN_E0=0xE0, NUM_NOTES=8, NOTE_NONE=15.
  - Function scan_to_note: 0x1C→0, 0x1B→1, 0x23→2, 0x2B→3, 0x34→4, 0x33→5, 0x3B→6, 0x42→7, otherwise NOTE_NONE.
  - Frequency table in centi-Hz: 26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325.
  - Function half_period(note, CLK_HZ) = (CLK_HZ*50 + f/2)/f.
- One sub-module, tone_voice: load/clear interface, active flag, counter, level.
- The engine instantiates NUM_VOICES tone_voice instances with a generate loop.

Test Plan:
- Reset, then iValid with 0x1C: oActive=0001 next cycle; oLastNote=0; voice0 toggles every 1911 cycles; oPWM duty ≈1/4 while level high.
- 0x1C, 0x1B, 0x23, 0x2B, then 0x34: voices 0–3 hold notes 0–3; the fifth make steals voice0, which reloads half-period 1276 (G4); steal pointer becomes 1.
- 0x1C twice (repeat): still only voice0 active, and its counter is not reset by the repeat.
- 0x1C, then 0xF0 0x1C: oActive=0000 the cycle after the second 0x1C; oPWM=0 thereafter.
- 0xE0 0x1C, then 0xE0 0xF0 0x1C, then 0x15 (unmapped): no voice ever active; oLastNote stays 15.
- Four notes held, then iMute=1 gives oPWM=0 constantly with oActive=1111. Asserting iReset mid-note clears oActive, oPWM and oLastNote immediately, without waiting for a clock edge.
